// File: rtl/cpu_data_bus_mmio.sv
// Data-side MMIO slave: word RAM, 32-bit timer/compare and, with CPU_MMIO_UART_EN defined, an 8N1 UART TX fed by a FIFO.
// Reads are combinational from data_addr; writes commit on the rising clk edge; the bus never stalls.
module cpu_mmio_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  // A push into a full FIFO is dropped even if a pop happens on the same edge.
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end
endmodule

module cpu_data_bus_mmio #(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_write,
  output logic [31:0] data_rdata,
  output logic        uart_tx,
  output logic        irq
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] count, cmp, status;
  logic        match;
  logic        ram_sel, cnt_sel, cmp_sel, sts_sel, sts_wr;
  logic        unused_addr_bits;

  assign ram_sel          = (data_addr[31:AW+2] == '0);
  assign cnt_sel          = (data_addr[31:2] == 30'h2000_0000);
  assign cmp_sel          = (data_addr[31:2] == 30'h2000_0001);
  assign sts_sel          = (data_addr[31:2] == 30'h2000_0002);
  assign sts_wr           = data_write & sts_sel;
  assign unused_addr_bits = ^data_addr[1:0];

  always_ff @(posedge clk) begin
    if (data_write && ram_sel) ram[data_addr[AW+1:2]] <= data_wdata;
  end

  // Match compares the pre-edge count; a set beats a W1C clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      cmp   <= '1;
      match <= 1'b0;
    end else begin
      count <= (data_write && cnt_sel) ? data_wdata : count + 32'd1;
      if (data_write && cmp_sel) cmp <= data_wdata;
      if (count == cmp) match <= 1'b1;
      else if (sts_wr && data_wdata[0]) match <= 1'b0;
    end
  end

  assign irq = match;

`ifdef CPU_MMIO_UART_EN
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt, fifo_dat;
  logic          tx_q, tx_nxt, bit_end, pop, push, fifo_full, fifo_empty, overflow;

  assign push    = data_write & (data_addr[31:2] == 30'h2000_0003);
  assign bit_end = (clk_cnt == LAST_CLK);

  cpu_mmio_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (data_wdata[7:0]),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow <= 1'b0;
    else if (push && fifo_full) overflow <= 1'b1;
    else if (sts_wr && data_wdata[4]) overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      tx_q    <= tx_nxt;
    end
  end

  // The line is driven from tx_q, so each bit value is loaded one edge before it must appear.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    tx_nxt      = tx_q;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shreg_nxt   = fifo_dat;
          tx_nxt      = 1'b0;
          clk_cnt_nxt = '0;
          state_nxt   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          bit_idx_nxt = '0;
          tx_nxt      = shreg[0];
          shreg_nxt   = {1'b0, shreg[7:1]};
          state_nxt   = DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
            tx_nxt      = shreg[0];
            shreg_nxt   = {1'b0, shreg[7:1]};
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_nxt = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shreg_nxt = fifo_dat;
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign uart_tx = tx_q;
  assign status  = {27'd0, overflow, fifo_empty, state != IDLE, fifo_full, match};
`else
  assign uart_tx = 1'b1;
  assign status  = {31'd0, match};
`endif

  always_comb begin
    data_rdata = '0;
    if (ram_sel) data_rdata = ram[data_addr[AW+1:2]];
    else if (cnt_sel) data_rdata = count;
    else if (cmp_sel) data_rdata = cmp;
    else if (sts_sel) data_rdata = status;
  end
endmodule

// File: tb/tb_cpu_data_bus_mmio.sv
// Directed plus randomized bench for cpu_data_bus_mmio against a cycle-level model of the programmer-visible state.
module tb_cpu_data_bus_mmio;
  localparam int RW    = 64;
  localparam int CPB   = 4;
  localparam int FD    = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] A_CNT = 32'h8000_0000;
  localparam logic [31:0] A_CMP = 32'h8000_0004;
  localparam logic [31:0] A_STS = 32'h8000_0008;
  localparam logic [31:0] A_TXD = 32'h8000_000C;
`ifdef CPU_MMIO_UART_EN
  localparam logic [31:0] IDLE_STS = 32'h8;
`else
  localparam logic [31:0] IDLE_STS = 32'h0;
`endif

  logic        clk, rst, data_write, uart_tx, irq;
  logic [31:0] data_addr, data_wdata, data_rdata;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] m_count, m_cmp;
  logic        m_match;
  logic [31:0] m_ram [int];
  logic [7:0]  tx_bytes [$];

  cpu_data_bus_mmio #(.RAM_WORDS(RW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_write (data_write),
    .data_rdata (data_rdata),
    .uart_tx    (uart_tx),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 32'd0;
    m_cmp   = 32'hFFFF_FFFF;
    m_match = 1'b0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    data_addr  = a;
    data_wdata = d;
    data_write = w;
    #1;
  endtask

  // Advance one clock; the model applies the bus transaction held across the edge.
  task automatic tick();
    logic [31:0] pre_cnt, pre_cmp, wa;
    pre_cnt = m_count;
    pre_cmp = m_cmp;
    wa      = {data_addr[31:2], 2'b00};
    @(posedge clk);
    if (data_write && wa == A_CNT) m_count = data_wdata;
    else m_count = pre_cnt + 32'd1;
    if (data_write && wa == A_CMP) m_cmp = data_wdata;
    if (pre_cnt == pre_cmp) m_match = 1'b1;
    else if (data_write && wa == A_STS && data_wdata[0]) m_match = 1'b0;
    if (data_write && wa < RW * 4) m_ram[int'(wa >> 2)] = data_wdata;
    @(negedge clk);
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (wa < RW * 4) return m_ram.exists(int'(wa >> 2)) ? m_ram[int'(wa >> 2)] : 32'hx;
    if (wa == A_CNT) return m_count;
    if (wa == A_CMP) return m_cmp;
    if (wa == A_STS) return IDLE_STS | {31'd0, m_match};
    return 32'd0;
  endfunction

  // Expected line level j cycles after the edge that wrote the first byte.
  function automatic logic exp_tx(input int j, input int nf);
    int f, k;
    if (j < 1 || j > nf * FRAME) return 1'b1;
    f = (j - 1) / FRAME;
    k = ((j - 1) % FRAME) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return tx_bytes[f][k-1];
    return 1'b1;
  endfunction

  task automatic uart_run(input int nwr, input logic [7:0] first, input int span);
    int nf;
    nf = (nwr > FD + 1) ? FD + 1 : nwr;
    tx_bytes.delete();
    tx_bytes.push_back(first);
    for (int i = 1; i < nwr; i++) tx_bytes.push_back(8'($urandom));
    for (int c = 0; c < span; c++) begin
      if (c < nwr) drive(A_TXD, {24'($urandom), tx_bytes[c]}, 1'b1);
      else if (nwr == 6 && c == 7) drive(A_STS, 32'h10, 1'b1);
      else drive(A_STS, 32'd0, 1'b0);
      if (c >= 1) check("uart_tx", uart_tx, exp_tx(c - 1, nf));
      if (c >= 1 && c >= nwr) check("tx_busy", data_rdata[2], (c - 1 >= 1) && (c - 1 <= nf * FRAME));
      if (nwr == 6 && c == 6) check("sts_ovf_set", data_rdata & 32'h1E, 32'h16);
      if (nwr == 6 && c == 8) check("sts_ovf_clr", data_rdata & 32'h1E, 32'h06);
      tick();
    end
    drive(A_STS, 32'd0, 1'b0);
    check("sts_idle_after", data_rdata & 32'h1E, 32'h08);
  endtask

  initial begin
    rst = 1'b1;
    data_addr = '0;
    data_wdata = '0;
    data_write = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_irq", irq, 1'b0);
    check("rst_uart_tx", uart_tx, 1'b1);
    drive(A_CNT, 32'd0, 1'b0); check("rst_count", data_rdata, 32'd0);
    drive(A_CMP, 32'd0, 1'b0); check("rst_cmp", data_rdata, 32'hFFFF_FFFF);
    drive(A_STS, 32'd0, 1'b0); check("rst_status", data_rdata, IDLE_STS);
    @(negedge clk);
    rst = 1'b0;

    // RAM: word write, aliasing of low address bits, top word, out-of-range reads.
    drive(32'h10, 32'hDEAD_BEEF, 1'b1); tick();
    drive(32'h12, 32'd0, 1'b0); check("ram_alias", data_rdata, 32'hDEAD_BEEF);
    drive(32'h10, 32'd0, 1'b0); check("ram_rd", data_rdata, 32'hDEAD_BEEF);
    drive(32'h9000_0000, 32'd0, 1'b0); check("unmapped_rd", data_rdata, 32'd0);
    drive(32'((RW - 1) * 4), 32'h1234_5678, 1'b1); tick();
    drive(32'((RW - 1) * 4 + 3), 32'd0, 1'b0); check("ram_top", data_rdata, 32'h1234_5678);
    drive(32'(RW * 4), 32'hFFFF_FFFF, 1'b1); tick();
    drive(32'(RW * 4), 32'd0, 1'b0); check("ram_past_end", data_rdata, 32'd0);
    drive(32'h0, 32'd0, 1'b0); check("ram_no_wrap", data_rdata === 32'hFFFF_FFFF, 1'b0);

    // Timer compare: count 5 written at edge E reaches 8 after E+3, match latches at E+4.
    drive(A_CNT, 32'd100, 1'b1); tick();
    drive(A_CMP, 32'd8, 1'b1); tick();
    drive(A_CNT, 32'd5, 1'b1); tick();
    for (int k = 1; k <= 5; k++) begin
      drive(A_CNT, 32'd0, 1'b0);
      check("tmr_count", data_rdata, 32'(4 + k));
      check("tmr_irq", irq, k >= 5);
      tick();
    end
    drive(A_STS, 32'd0, 1'b0); check("sts_match", data_rdata & 32'h1, 32'h1);
    drive(A_STS, 32'h1, 1'b1); check("irq_pre_clr", irq, 1'b1); tick();
    drive(A_STS, 32'd0, 1'b0); check("irq_clr", irq, 1'b0);
    check("sts_match_clr", data_rdata, IDLE_STS);

    // Timer wrap with cmp=0.
    drive(A_CNT, 32'hFFFF_FFFE, 1'b1); tick();
    drive(A_CMP, 32'd0, 1'b1); tick();
    drive(A_CNT, 32'd0, 1'b0); check("wrap_ff", data_rdata, 32'hFFFF_FFFF); check("wrap_irq0", irq, 1'b0); tick();
    drive(A_CNT, 32'd0, 1'b0); check("wrap_0", data_rdata, 32'd0); check("wrap_irq1", irq, 1'b0); tick();
    drive(A_CNT, 32'd0, 1'b0); check("wrap_1", data_rdata, 32'd1); check("wrap_irq2", irq, 1'b1);
    drive(A_STS, 32'h1, 1'b1); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int          op;
      logic [31:0] a, d, e;
      logic        w;
      op = $urandom_range(0, 7);
      d  = $urandom;
      w  = 1'b0;
      case (op)
        0: begin a = 32'($urandom_range(0, RW - 1)) * 4 + 32'($urandom_range(0, 3)); w = 1'b1; end
        1: a = 32'($urandom_range(0, RW - 1)) * 4 + 32'($urandom_range(0, 3));
        2: begin a = A_CNT; d = m_cmp - 32'($urandom_range(0, 6)); w = 1'b1; end
        3: begin a = A_CMP; d = m_count + 32'($urandom_range(0, 6)); w = 1'b1; end
        4: begin a = A_STS; w = 1'b1; end
        5: a = A_CNT + 32'($urandom_range(0, 2)) * 4 + 32'($urandom_range(0, 3));
        6: begin a = 32'h8000_0010 + 32'($urandom_range(0, 1000)) * 4; w = $urandom_range(0, 1) == 1; end
        default: begin a = 32'(RW * 4) + 32'($urandom_range(0, 5000)) * 4; w = $urandom_range(0, 1) == 1; end
      endcase
      drive(a, d, w);
      e = exp_rd(a);
      if (!$isunknown(e)) check("rand_rd", data_rdata, e);
      check("rand_irq", irq, m_match);
      tick();
    end

`ifdef CPU_MMIO_UART_EN
    uart_run(1, 8'hA5, 44);
    uart_run(6, 8'h3C, 5 * FRAME + 5);
`else
    drive(A_TXD, 32'h55, 1'b1); tick();
    for (int c = 0; c < 50; c++) begin
      drive(A_STS, 32'd0, 1'b0);
      check("tx_tied_high", uart_tx, 1'b1);
      check("sts_uart_bits", data_rdata & 32'h1E, 32'd0);
      tick();
    end
`endif

    // Reset in the middle of a frame with bytes still queued.
    drive(A_CMP, m_count + 32'd4, 1'b1); tick();
    for (int c = 0; c < 3; c++) begin drive(A_TXD, 32'($urandom), 1'b1); tick(); end
    for (int c = 0; c < 20; c++) begin drive(A_STS, 32'd0, 1'b0); tick(); end
    check("pre_rst_irq", irq, m_match);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_tx", uart_tx, 1'b1);
    check("mid_rst_irq", irq, 1'b0);
    drive(A_STS, 32'd0, 1'b0); check("mid_rst_sts", data_rdata, IDLE_STS);
    drive(A_CNT, 32'd0, 1'b0); check("mid_rst_cnt", data_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 60; c++) begin
      drive(A_STS, 32'd0, 1'b0);
      check("post_rst_tx", uart_tx, 1'b1);
      check("post_rst_sts", data_rdata, IDLE_STS | {31'd0, m_match});
      tick();
    end
    drive(A_CNT, 32'd0, 1'b0); check("post_rst_cnt", data_rdata, m_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
